// File: rtl/scan_sequencer.sv
// Channel scan sequencer for a 3:8 decoder. It steps through the enabled channels,
// inserting a one-cycle blank (e=0) before every channel select change.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               e,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE, DONE} state_t;

  state_t             state_r, state_s;
  logic [2:0]         sel_r, sel_s;
  logic [DWELL_W-1:0] cnt_r, cnt_s;
  logic [7:0]         mask_r, mask_s;
  logic               mode_r, mode_s;
  logic               e_r, e_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  function automatic logic [2:0] lowest_chan(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] highest_chan(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Upward search from cur+1 with 7->0 wrap; a lone channel finds itself.
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    r = cur;
    for (int k = 7; k >= 1; k--) begin
      idx = cur + 3'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  // State, scan configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_r   <= 3'd0;
      cnt_r   <= '0;
      mask_r  <= 8'd0;
      mode_r  <= 1'b0;
      e_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      cnt_r   <= cnt_s;
      mask_r  <= mask_s;
      mode_r  <= mode_s;
      e_r     <= e_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    cnt_s   = cnt_r;
    mask_s  = mask_r;
    mode_s  = mode_r;
    case (state_r)
      IDLE: begin
        if (start && !stop && (mask != 8'd0)) begin
          mask_s  = mask;
          mode_s  = mode;
          sel_s   = lowest_chan(mask);
          state_s = BLANK;
        end else begin
          state_s = IDLE;
        end
      end
      BLANK: begin
        if (stop) begin
          state_s = IDLE;
        end else begin
          cnt_s   = (dwell == '0) ? DWELL_W'(1) : dwell;
          state_s = DRIVE;
        end
      end
      DRIVE: begin
        if (stop) begin
          state_s = IDLE;
        end else if (cnt_r <= DWELL_W'(1)) begin
          if (mode_r && (sel_r == highest_chan(mask_r))) begin
            state_s = DONE;
          end else begin
            sel_s   = next_chan(mask_r, sel_r);
            state_s = BLANK;
          end
        end else begin
          cnt_s = cnt_r - DWELL_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    e_s    = (state_s == DRIVE);
    busy_s = (state_s == BLANK) || (state_s == DRIVE);
    done_s = (state_s == DONE);
  end

  assign {a, b, c} = sel_r;
  assign e         = e_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed scenarios plus randomized scans
// compared cycle by cycle against a channel-list reference model.
module tb_scan_sequencer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    mask = 8'd0;
  logic [DW-1:0] dwell = '0;
  logic          a, b, c, e, busy, done;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .a(a), .b(b), .c(c), .e(e), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed {sel,e,busy,done}=%b required=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle {sel,e,busy,done}: one blank cycle then max(dwell,1) drive cycles per enabled channel.
  task automatic build_model(input logic [7:0] m, input logic md, input logic [DW-1:0] dw, input int limit);
    int chans[$];
    int n;
    int k;
    exp_q.delete();
    n = (dw == '0) ? 1 : int'(dw);
    k = 0;
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    if (md) begin
      foreach (chans[j]) begin
        exp_q.push_back({3'(chans[j]), 3'b010});
        repeat (n) exp_q.push_back({3'(chans[j]), 3'b110});
      end
      exp_q.push_back({3'(chans[chans.size()-1]), 3'b001});
      repeat (2) exp_q.push_back(6'b000000);
    end else begin
      while (exp_q.size() < limit) begin
        exp_q.push_back({3'(chans[k % chans.size()]), 3'b010});
        repeat (n) exp_q.push_back({3'(chans[k % chans.size()]), 3'b110});
        k++;
      end
    end
  endtask

  // Runs one scan; mid-scan start/mask/mode are scrambled to show they are ignored.
  task automatic run_scan(input logic [7:0] m, input logic md, input logic [DW-1:0] dw,
                          input int stop_at, input string tag);
    int len;
    logic [5:0] obs;
    build_model(m, md, dw, stop_at);
    len = md ? exp_q.size() : stop_at;
    mask = m; mode = md; dwell = dw; start = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      obs = {a, b, c, e, busy, done};
      if (exp_q[i][2:0] == 3'b000) check($sformatf("%s[%0d]", tag, i), {3'b000, obs[2:0]}, 6'b000000);
      else check($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
      if (exp_q[i][1] || exp_q[i][0]) begin
        start = 1'($urandom);
        mask  = 8'($urandom);
        mode  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!md) begin
      stop = 1'b1;
      tick();
      check({tag, "_stop"}, {3'b000, e, busy, done}, 6'b000000);
      stop = 1'b0; start = 1'b0;
      tick();
      check({tag, "_after_stop"}, {3'b000, e, busy, done}, 6'b000000);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] rm;
    logic [DW-1:0] rd;
    #2;
    check("reset_state", {a, b, c, e, busy, done}, 6'b000000);
    #10 rst_n = 1'b1;
    tick();
    check("idle_after_reset", {a, b, c, e, busy, done}, 6'b000000);

    run_scan(8'h05, 1'b1, DW'(2), 0, "single_05");
    run_scan(8'h81, 1'b0, DW'(1), 12, "wrap_81");
    run_scan(8'h10, 1'b1, DW'(0), 0, "zero_dwell");

    mask = 8'h00; mode = 1'b1; dwell = DW'(2); start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mask0_start[%0d]", i), {3'b000, e, busy, done}, 6'b000000);
    end
    start = 1'b0;

    mask = 8'h0f; start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("start_stop_idle[%0d]", i), {3'b000, e, busy, done}, 6'b000000);
    end
    start = 1'b0; stop = 1'b0;

    for (int it = 0; it < 6; it++) begin
      rm = 8'($urandom_range(1, 255));
      rd = DW'($urandom_range(0, 3));
      run_scan(rm, 1'b1, rd, 0, $sformatf("rnd_single%0d", it));
      rm = 8'($urandom_range(1, 255));
      rd = DW'($urandom_range(0, 3));
      run_scan(rm, 1'b0, rd, int'($urandom_range(1, 20)), $sformatf("rnd_cont%0d", it));
    end

    mask = 8'h24; mode = 1'b0; dwell = DW'(5); start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_mid_blank", {a, b, c, e, busy, done}, {3'd2, 3'b010});
    tick();
    check("rst_mid_drive", {a, b, c, e, busy, done}, {3'd2, 3'b110});
    #2 rst_n = 1'b0;
    #1 check("async_reset", {a, b, c, e, busy, done}, 6'b000000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset_idle[%0d]", i), {a, b, c, e, busy, done}, 6'b000000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
